cnn_layer_accel_weight_table_ctrl: RTL and testbench

- Sequencer for the per-CE weight table.
- Accepts a job descriptor (kernel count, output format, pass length), then streams 3x3 kernel weights into the table in config mode.
- Then runs execution passes: drives ce_execute, pulses next_kernel at each kernel boundary, and signals job completion once the table read pipeline has drained.
- Sits between the layer job dispatcher / weight DMA stream and the weight table block.

---
 rtl/cnn_layer_accel_wht_ctrl_pkg.sv | 32 +++
 rtl/cnn_layer_accel_wht_pass_timer.sv | 76 +++++++
 rtl/cnn_layer_accel_weight_table_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_cnn_layer_accel_weight_table_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_wht_ctrl_pkg.sv
// Shared types and helpers for the weight table sequencer.
`ifndef CONV_OUT_FMT0
`define CONV_OUT_FMT0 1'b0
`endif
`ifndef CONV_OUT_FMT1
`define CONV_OUT_FMT1 1'b1
`endif
`ifndef MAX_BRAM_3x3_KERNELS
`define MAX_BRAM_3x3_KERNELS 32
`endif

package cnn_layer_accel_wht_ctrl_pkg;

    localparam int unsigned C_KERNEL_WORDS_DEF = 9;
    localparam int unsigned C_WHT_WORD_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_LOAD   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } wht_ctrl_state_e;

    // Number of weight words a job loads: one full kernel per table entry.
    function automatic int unsigned total_words(input int unsigned num_kernels_m1,
                                                input int unsigned kernel_words);
        return (num_kernels_m1 + 32'd1) * kernel_words;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_wht_pass_timer.sv
// Execute-pass timer: per-kernel cycle counter, kernel counter, next_kernel strobe.
module cnn_layer_accel_wht_pass_timer #(
    parameter int unsigned C_KW_WIDTH = 5,
    parameter int unsigned C_PL_WIDTH = 16
) (
    input  logic                  clk_core,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic [C_PL_WIDTH-1:0] pass_len,
    input  logic [C_KW_WIDTH-1:0] num_kernels,
    output logic                  next_kernel,
    output logic                  last_pass_c
);

    logic                  active_q, active_d;
    logic [C_PL_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [C_KW_WIDTH-1:0] kern_cnt_q, kern_cnt_d;
    logic                  next_kernel_q, next_kernel_d;
    logic [C_PL_WIDTH-1:0] pass_len_m1;
    logic [C_PL_WIDTH-1:0] cyc_inc;

    // pass_len is never 0 here; the controller forces 0 to 1 when latching
    assign pass_len_m1 = pass_len - C_PL_WIDTH'(1);
    assign cyc_inc     = cyc_cnt_q + C_PL_WIDTH'(1);

    // Boundary of the final kernel: the controller leaves EXEC on this cycle
    assign last_pass_c = active_q && next_kernel_q && (kern_cnt_q == num_kernels);
    assign next_kernel = next_kernel_q;

    // Counter sequencing; next_kernel is precomputed so it lines up with the last cycle of a pass
    always_comb begin
        active_d      = active_q;
        cyc_cnt_d     = cyc_cnt_q;
        kern_cnt_d    = kern_cnt_q;
        next_kernel_d = 1'b0;
        if (clear) begin
            active_d   = 1'b0;
            cyc_cnt_d  = '0;
            kern_cnt_d = '0;
        end else if (stop) begin
            active_d = 1'b0;
        end else if (start) begin
            active_d      = 1'b1;
            cyc_cnt_d     = '0;
            kern_cnt_d    = '0;
            next_kernel_d = (pass_len_m1 == '0);
        end else if (active_q) begin
            if (next_kernel_q) begin
                cyc_cnt_d     = '0;
                kern_cnt_d    = kern_cnt_q + C_KW_WIDTH'(1);
                next_kernel_d = (pass_len_m1 == '0);
            end else begin
                cyc_cnt_d     = cyc_inc;
                next_kernel_d = (cyc_inc == pass_len_m1);
            end
        end
    end

    // Timer state registers
    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            active_q      <= 1'b0;
            cyc_cnt_q     <= '0;
            kern_cnt_q    <= '0;
            next_kernel_q <= 1'b0;
        end else begin
            active_q      <= active_d;
            cyc_cnt_q     <= cyc_cnt_d;
            kern_cnt_q    <= kern_cnt_d;
            next_kernel_q <= next_kernel_d;
        end
    end

endmodule

// File: rtl/cnn_layer_accel_weight_table_ctrl.sv
// Weight table sequencer: job accept, config-mode weight load, execute passes, drain, done.
module cnn_layer_accel_weight_table_ctrl
    import cnn_layer_accel_wht_ctrl_pkg::*;
#(
    parameter int unsigned C_KERNEL_WORDS              = C_KERNEL_WORDS_DEF,
    parameter int unsigned C_CLG2_MAX_BRAM_3x3_KERNELS = 5,
    parameter int unsigned C_PASS_LEN_WIDTH            = 16,
    parameter int unsigned C_DRAIN_CYCLES              = 6
) (
    input  logic                                   clk_core,
    input  logic                                   rst,
    input  logic                                   job_valid,
    output logic                                   job_ready,
    input  logic [C_CLG2_MAX_BRAM_3x3_KERNELS-1:0] job_num_kernels,
    input  logic                                   job_conv_out_fmt,
    input  logic [C_PASS_LEN_WIDTH-1:0]            job_pass_len,
    input  logic                                   abort,
    input  logic                                   wht_in_valid,
    output logic                                   wht_in_ready,
    input  logic [C_WHT_WORD_WIDTH-1:0]            wht_in_data,
    output logic                                   config_mode,
    output logic                                   job_accept,
    output logic                                   wht_config_wren,
    output logic [C_WHT_WORD_WIDTH-1:0]            wht_config_data,
    output logic                                   ce_execute,
    output logic                                   next_kernel,
    input  logic                                   last_kernel,
    output logic                                   conv_out_fmt,
    output logic [C_CLG2_MAX_BRAM_3x3_KERNELS-1:0] num_kernels,
    output logic                                   job_done,
    output logic                                   err_kernel_mismatch
);

    localparam int unsigned C_KW_W = C_CLG2_MAX_BRAM_3x3_KERNELS;
    localparam int unsigned C_PL_W = C_PASS_LEN_WIDTH;
    localparam int unsigned C_WC_W = $clog2(`MAX_BRAM_3x3_KERNELS * C_KERNEL_WORDS) + 1;
    localparam int unsigned C_DC_W = $clog2(C_DRAIN_CYCLES + 1);

    wht_ctrl_state_e               state_q, state_d;
    logic                          job_ready_q, job_ready_d;
    logic                          job_accept_q, job_accept_d;
    logic                          config_mode_q, config_mode_d;
    logic                          wht_in_ready_q, wht_in_ready_d;
    logic                          wren_q, wren_d;
    logic [C_WHT_WORD_WIDTH-1:0]   wdata_q, wdata_d;
    logic                          ce_execute_q, ce_execute_d;
    logic                          conv_out_fmt_q, conv_out_fmt_d;
    logic [C_KW_W-1:0]             num_kernels_q, num_kernels_d;
    logic                          job_done_q, job_done_d;
    logic                          err_q, err_d;
    logic [C_PL_W-1:0]             pass_len_q, pass_len_d;
    logic [C_WC_W-1:0]             word_cnt_q, word_cnt_d;
    logic [C_DC_W-1:0]             drain_cnt_q, drain_cnt_d;
    logic                          lk_seen_q, lk_seen_d;

    logic                          job_hs;
    logic                          exec_start;
    logic                          timer_stop;
    logic                          pass_end_c;
    logic [C_WC_W-1:0]             total_words_c;

    assign total_words_c = C_WC_W'(total_words(32'(num_kernels_q), C_KERNEL_WORDS));
    assign timer_stop    = abort || pass_end_c;

    cnn_layer_accel_wht_pass_timer #(
        .C_KW_WIDTH (C_KW_W),
        .C_PL_WIDTH (C_PL_W)
    ) u_pass_timer (
        .clk_core    (clk_core),
        .rst         (rst),
        .clear       (job_hs),
        .start       (exec_start),
        .stop        (timer_stop),
        .pass_len    (pass_len_q),
        .num_kernels (num_kernels_q),
        .next_kernel (next_kernel),
        .last_pass_c (pass_end_c)
    );

    // Next-state and registered-output decode; abort in any busy state returns to IDLE
    always_comb begin
        state_d        = state_q;
        job_ready_d    = 1'b0;
        job_accept_d   = 1'b0;
        config_mode_d  = 1'b0;
        wht_in_ready_d = 1'b0;
        wren_d         = 1'b0;
        wdata_d        = wdata_q;
        ce_execute_d   = 1'b0;
        conv_out_fmt_d = conv_out_fmt_q;
        num_kernels_d  = num_kernels_q;
        job_done_d     = 1'b0;
        err_d          = err_q;
        pass_len_d     = pass_len_q;
        word_cnt_d     = word_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        lk_seen_d      = lk_seen_q;
        exec_start     = 1'b0;
        job_hs         = 1'b0;

        if (last_kernel && (state_q == ST_EXEC || state_q == ST_DRAIN)) begin
            lk_seen_d = 1'b1;
        end

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    job_ready_d = 1'b1;
                    if (job_valid && job_ready_q) begin
                        job_hs         = 1'b1;
                        state_d        = ST_ACCEPT;
                        job_ready_d    = 1'b0;
                        job_accept_d   = 1'b1;
                        config_mode_d  = 1'b1;
                        num_kernels_d  = job_num_kernels;
                        conv_out_fmt_d = job_conv_out_fmt;
                        pass_len_d     = (job_pass_len == '0) ? C_PL_W'(1) : job_pass_len;
                        word_cnt_d     = '0;
                        err_d          = 1'b0;
                        lk_seen_d      = 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    state_d        = ST_LOAD;
                    config_mode_d  = 1'b1;
                    wht_in_ready_d = 1'b1;
                end
                ST_LOAD: begin
                    if (word_cnt_q == total_words_c) begin
                        // final write is on the bus this cycle; leave config mode next
                        state_d      = ST_EXEC;
                        ce_execute_d = 1'b1;
                        exec_start   = 1'b1;
                    end else begin
                        config_mode_d = 1'b1;
                        if (wht_in_valid && wht_in_ready_q) begin
                            wren_d     = 1'b1;
                            wdata_d    = wht_in_data;
                            word_cnt_d = word_cnt_q + C_WC_W'(1);
                        end
                        // drop ready on the last beat so nothing beyond the table is taken
                        wht_in_ready_d = (word_cnt_d != total_words_c);
                    end
                end
                ST_EXEC: begin
                    if (pass_end_c) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end else begin
                        ce_execute_d = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == C_DC_W'(C_DRAIN_CYCLES - 1)) begin
                        state_d    = ST_DONE;
                        job_done_d = 1'b1;
                        if (!(lk_seen_q || last_kernel)) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        drain_cnt_d = drain_cnt_q + C_DC_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            job_ready_q    <= 1'b0;
            job_accept_q   <= 1'b0;
            config_mode_q  <= 1'b0;
            wht_in_ready_q <= 1'b0;
            wren_q         <= 1'b0;
            wdata_q        <= '0;
            ce_execute_q   <= 1'b0;
            conv_out_fmt_q <= `CONV_OUT_FMT0;
            num_kernels_q  <= '0;
            job_done_q     <= 1'b0;
            err_q          <= 1'b0;
            pass_len_q     <= C_PL_W'(1);
            word_cnt_q     <= '0;
            drain_cnt_q    <= '0;
            lk_seen_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            job_ready_q    <= job_ready_d;
            job_accept_q   <= job_accept_d;
            config_mode_q  <= config_mode_d;
            wht_in_ready_q <= wht_in_ready_d;
            wren_q         <= wren_d;
            wdata_q        <= wdata_d;
            ce_execute_q   <= ce_execute_d;
            conv_out_fmt_q <= conv_out_fmt_d;
            num_kernels_q  <= num_kernels_d;
            job_done_q     <= job_done_d;
            err_q          <= err_d;
            pass_len_q     <= pass_len_d;
            word_cnt_q     <= word_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            lk_seen_q      <= lk_seen_d;
        end
    end

    assign job_ready           = job_ready_q;
    assign job_accept          = job_accept_q;
    assign config_mode         = config_mode_q;
    assign wht_in_ready        = wht_in_ready_q;
    assign wht_config_wren     = wren_q;
    assign wht_config_data     = wdata_q;
    assign ce_execute          = ce_execute_q;
    assign conv_out_fmt        = conv_out_fmt_q;
    assign num_kernels         = num_kernels_q;
    assign job_done            = job_done_q;
    assign err_kernel_mismatch = err_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_table_ctrl.sv
// Bench for the weight table sequencer: job table, random jobs, abort and reset sequences.
module tb_cnn_layer_accel_weight_table_ctrl;

    logic        clk_core = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [4:0]  job_num_kernels;
    logic        job_conv_out_fmt;
    logic [15:0] job_pass_len;
    logic        abort;
    logic        wht_in_valid;
    logic        wht_in_ready;
    logic [15:0] wht_in_data;
    logic        config_mode;
    logic        job_accept;
    logic        wht_config_wren;
    logic [15:0] wht_config_data;
    logic        ce_execute;
    logic        next_kernel;
    logic        last_kernel;
    logic        conv_out_fmt;
    logic [4:0]  num_kernels;
    logic        job_done;
    logic        err_kernel_mismatch;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  nk;
        logic [15:0] pass_len;
        logic        fmt;
        int          stall;       // 0 continuous, 1 toggling, 2 random
        logic        lk;          // drive last_kernel during execute
        int          exp_writes;
        int          exp_ce;
        int          exp_nkp;
        int          exp_err;
    } vec_t;

    cnn_layer_accel_weight_table_ctrl dut (
        .clk_core            (clk_core),
        .rst                 (rst),
        .job_valid           (job_valid),
        .job_ready           (job_ready),
        .job_num_kernels     (job_num_kernels),
        .job_conv_out_fmt    (job_conv_out_fmt),
        .job_pass_len        (job_pass_len),
        .abort               (abort),
        .wht_in_valid        (wht_in_valid),
        .wht_in_ready        (wht_in_ready),
        .wht_in_data         (wht_in_data),
        .config_mode         (config_mode),
        .job_accept          (job_accept),
        .wht_config_wren     (wht_config_wren),
        .wht_config_data     (wht_config_data),
        .ce_execute          (ce_execute),
        .next_kernel         (next_kernel),
        .last_kernel         (last_kernel),
        .conv_out_fmt        (conv_out_fmt),
        .num_kernels         (num_kernels),
        .job_done            (job_done),
        .err_kernel_mismatch (err_kernel_mismatch)
    );

    always #5 clk_core = ~clk_core;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference model: job observables from the descriptor alone
    function automatic vec_t model(input logic [4:0] nk, input logic [15:0] pl,
                                   input logic fmt, input int stall, input logic lk);
        vec_t v;
        int   p;
        p            = (pl == 16'd0) ? 1 : int'(pl);
        v.nk         = nk;
        v.pass_len   = pl;
        v.fmt        = fmt;
        v.stall      = stall;
        v.lk         = lk;
        v.exp_writes = (int'(nk) + 1) * 9;
        v.exp_ce     = (int'(nk) + 1) * p;
        v.exp_nkp    = int'(nk) + 1;
        v.exp_err    = lk ? 0 : 1;
        return v;
    endfunction

    task automatic start_job(input logic [4:0] nk, input logic [15:0] pl, input logic fmt);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_core);
            if (job_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("job_ready_wait", int'(ok), 1);
        job_num_kernels  = nk;
        job_pass_len     = pl;
        job_conv_out_fmt = fmt;
        job_valid        = 1'b1;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        logic [15:0] words [320];
        int   cyc, sent, wr_cnt, wr_bad, acc_cnt, ce_cnt, nk_cnt, nk_bad;
        int   last_wr, cfg_fall, ce_first, ce_fall, done_cyc, err_acc, err_done, plen;
        int   fmt_done, nk_done;
        bit   done, prev_cfg, prev_ce;
        for (int i = 0; i < 320; i++) words[i] = 16'($urandom);
        plen = (v.pass_len == 16'd0) ? 1 : int'(v.pass_len);
        cyc = 0; sent = 0; wr_cnt = 0; wr_bad = 0; acc_cnt = 0; ce_cnt = 0;
        nk_cnt = 0; nk_bad = 0; last_wr = -100; cfg_fall = -1; ce_first = -1;
        ce_fall = -1; done_cyc = -1; err_acc = -1; err_done = -1; fmt_done = -1;
        nk_done = -1; done = 1'b0; prev_cfg = 1'b0; prev_ce = 1'b0;
        wht_in_valid = 1'b0;
        start_job(v.nk, v.pass_len, v.fmt);
        while (!done && cyc < 4000) begin
            @(negedge clk_core);
            cyc++;
            job_valid = 1'b0;
            if (job_accept) begin
                acc_cnt++;
                err_acc = int'(err_kernel_mismatch);
            end
            if (wht_config_wren) begin
                if (wht_config_data !== words[wr_cnt]) wr_bad++;
                if (wr_cnt < 319) wr_cnt++;
                last_wr = cyc;
            end
            if (prev_cfg && !config_mode) cfg_fall = cyc;
            if (ce_execute) begin
                ce_cnt++;
                if (ce_first < 0) ce_first = cyc;
            end
            if (next_kernel) begin
                nk_cnt++;
                if (!ce_execute || (ce_cnt % plen) != 0) nk_bad++;
            end
            if (prev_ce && !ce_execute) ce_fall = cyc;
            if (job_done) begin
                done     = 1'b1;
                done_cyc = cyc;
                err_done = int'(err_kernel_mismatch);
                fmt_done = int'(conv_out_fmt);
                nk_done  = int'(num_kernels);
            end
            prev_cfg = config_mode;
            prev_ce  = ce_execute;
            case (v.stall)
                0:       wht_in_valid = 1'b1;
                1:       wht_in_valid = ((cyc % 2) == 0);
                default: wht_in_valid = 1'($urandom_range(0, 1));
            endcase
            wht_in_data = words[sent];
            last_kernel = v.lk && ce_execute;
            if (wht_in_valid && wht_in_ready && sent < 319) sent++;
        end
        wht_in_valid = 1'b0;
        last_kernel  = 1'b0;
        check({tag, "_done_seen"}, int'(done), 1);
        check({tag, "_accept_pulses"}, acc_cnt, 1);
        check({tag, "_err_at_accept"}, err_acc, 0);
        check({tag, "_writes"}, wr_cnt, v.exp_writes);
        check({tag, "_beats_taken"}, sent, v.exp_writes);
        check({tag, "_write_data_bad"}, wr_bad, 0);
        check({tag, "_cfg_fall_after_last_write"}, cfg_fall - last_wr, 1);
        check({tag, "_ce_start_at_cfg_fall"}, ce_first - cfg_fall, 0);
        check({tag, "_ce_cycles"}, ce_cnt, v.exp_ce);
        check({tag, "_next_kernel_pulses"}, nk_cnt, v.exp_nkp);
        check({tag, "_next_kernel_misplaced"}, nk_bad, 0);
        check({tag, "_done_after_ce_fall"}, done_cyc - ce_fall, 6);
        check({tag, "_err_at_done"}, err_done, v.exp_err);
        check({tag, "_fmt"}, fmt_done, int'(v.fmt));
        check({tag, "_num_kernels"}, nk_done, int'(v.nk));
        @(negedge clk_core);
        check({tag, "_done_one_cycle"}, int'(job_done), 0);
    endtask

    initial begin
        vec_t tbl [5];
        int   sent, guard, dn, ce_seen;

        tbl[0] = '{5'd1, 16'd4, 1'b0, 0, 1'b1, 18,  8, 2, 0};
        tbl[1] = '{5'd0, 16'd3, 1'b1, 1, 1'b1,  9,  3, 1, 0};
        tbl[2] = '{5'd2, 16'd0, 1'b0, 0, 1'b1, 27,  3, 3, 0};
        tbl[3] = '{5'd0, 16'd1, 1'b1, 0, 1'b0,  9,  1, 1, 1};
        tbl[4] = '{5'd3, 16'd2, 1'b1, 2, 1'b1, 36,  8, 4, 0};

        rst = 1'b1; job_valid = 1'b0; job_num_kernels = '0; job_conv_out_fmt = 1'b0;
        job_pass_len = '0; abort = 1'b0; wht_in_valid = 1'b0; wht_in_data = '0;
        last_kernel = 1'b0;

        // reset values
        repeat (3) @(negedge clk_core);
        check("rst_strobes", int'({job_ready, job_accept, config_mode, wht_in_ready,
              wht_config_wren, ce_execute, next_kernel, conv_out_fmt, job_done,
              err_kernel_mismatch}), 0);
        check("rst_num_kernels", int'(num_kernels), 0);
        check("rst_wdata", int'(wht_config_data), 0);
        rst = 1'b0;
        check("rst_ready_before_edge", int'(job_ready), 0);
        @(negedge clk_core);
        check("rst_ready_after_edge", int'(job_ready), 1);

        for (int i = 0; i < 5; i++) run_job(tbl[i], $sformatf("tbl%0d", i));

        // abort during load after five beats
        start_job(5'd1, 16'd4, 1'b1);
        sent = 0; guard = 0;
        while (sent < 5 && guard < 200) begin
            @(negedge clk_core);
            guard++;
            job_valid    = 1'b0;
            wht_in_valid = 1'b1;
            wht_in_data  = 16'(guard);
            if (wht_in_ready) sent++;
        end
        @(negedge clk_core);
        abort = 1'b1;
        wht_in_valid = 1'b1;
        @(negedge clk_core);
        abort = 1'b0;
        wht_in_valid = 1'b0;
        check("abort_config_mode", int'(config_mode), 0);
        check("abort_wht_in_ready", int'(wht_in_ready), 0);
        check("abort_no_write", int'(wht_config_wren), 0);
        check("abort_ready_first", int'(job_ready), 0);
        check("abort_fmt_retained", int'(conv_out_fmt), 1);
        @(negedge clk_core);
        check("abort_ready_later", int'(job_ready), 1);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_core);
            if (job_done || ce_execute) dn++;
        end
        check("abort_no_done", dn, 0);
        run_job(model(5'd0, 16'd2, 1'b0, 0, 1'b1), "post_abort");

        // async reset in the middle of execute
        start_job(5'd7, 16'd1, 1'b1);
        ce_seen = 0;
        for (int i = 0; i < 500 && ce_seen < 3; i++) begin
            @(negedge clk_core);
            job_valid    = 1'b0;
            wht_in_valid = 1'b1;
            wht_in_data  = 16'($urandom);
            if (ce_execute) ce_seen++;
        end
        check("rstx_pre_ce", int'(ce_execute), 1);
        check("rstx_pre_next_kernel", int'(next_kernel), 1);
        #2 rst = 1'b1;
        #1;
        check("rstx_ce_async", int'(ce_execute), 0);
        check("rstx_next_kernel_async", int'(next_kernel), 0);
        wht_in_valid = 1'b0;
        repeat (2) @(negedge clk_core);
        rst = 1'b0;
        check("rstx_ready_before_edge", int'(job_ready), 0);
        @(negedge clk_core);
        check("rstx_ready_after_edge", int'(job_ready), 1);

        // random jobs against the model
        for (int i = 0; i < 6; i++) begin
            run_job(model(5'($urandom_range(0, 4)), 16'($urandom_range(0, 5)),
                          1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1))),
                    $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
